// File: rtl/execute_stage_p_pkg.sv
// Shared encodings for the execute stage: ALU ops, conditions,
// CCR bit positions and the multiply sequencer states.
package execute_stage_p_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_NAND  = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_C      = 2'd1;
  localparam logic [1:0] COND_Z      = 2'd2;
  localparam logic [1:0] COND_NEVER  = 2'd3;

  localparam int CCR_Z = 1;
  localparam int CCR_C = 0;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  function automatic logic cond_pass(
    input logic [1:0] cond,
    input logic [1:0] ccr
  );
    logic p;
    unique case (cond)
      COND_ALWAYS: p = 1'b1;
      COND_C:      p = ccr[CCR_C];
      COND_Z:      p = ccr[CCR_Z];
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/execute_stage_p_if.sv
// Issue-side and EX/MEM-side signal bundle of the execute stage.
// master drives instructions in; slave is the stage itself.
interface execute_stage_p_if #(
  parameter int WIDTH = 16,
  parameter int NFWD  = 4,
  parameter int SELW  = $clog2(NFWD + 1)
) ();

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [2:0]        op;
  logic [1:0]        cond;
  logic              ccr_en;
  logic              wb_en_in;
  logic [WIDTH-1:0]  rf_out1;
  logic [WIDTH-1:0]  rf_out2;
  logic [WIDTH-1:0]  simm;
  logic              src1_imm;
  logic              src2_imm;
  logic [SELW-1:0]   fwd_sel1;
  logic [SELW-1:0]   fwd_sel2;
  logic [NFWD*WIDTH-1:0] fwd_data;
  logic [WIDTH-1:0]  pc_plus1;
  logic              ra_sel;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  alu_out;
  logic [WIDTH-1:0]  ra_out;
  logic              wb_en;
  logic [1:0]        ccr;
  logic              busy;

  modport master (
    output in_valid, flush, op, cond, ccr_en, wb_en_in,
    output rf_out1, rf_out2, simm, src1_imm, src2_imm,
    output fwd_sel1, fwd_sel2, fwd_data, pc_plus1, ra_sel,
    output out_ready,
    input  in_ready, out_valid, alu_out, ra_out, wb_en, ccr, busy
  );

  modport slave (
    input  in_valid, flush, op, cond, ccr_en, wb_en_in,
    input  rf_out1, rf_out2, simm, src1_imm, src2_imm,
    input  fwd_sel1, fwd_sel2, fwd_data, pc_plus1, ra_sel,
    input  out_ready,
    output in_ready, out_valid, alu_out, ra_out, wb_en, ccr, busy
  );

endinterface

// File: rtl/execute_stage_p_fwd_mux.sv
// Forwarding operand select: 0 (or out of range) passes the
// register/immediate value, k picks forwarding slot k-1.
module fwd_mux_p #(
  parameter int WIDTH = 16,
  parameter int NFWD  = 4,
  parameter int SELW  = $clog2(NFWD + 1)
) (
  input  logic [SELW-1:0]       sel_i,
  input  logic [NFWD*WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0]      mux_i,
  output logic [WIDTH-1:0]      y_o
);

  always_comb begin
    y_o = mux_i;
    for (int k = 1; k <= NFWD; k++) begin
      if (sel_i == SELW'(k)) y_o = data_i[(k-1)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/execute_stage_p.sv
// Execute stage: operand select, conditional execute, single-cycle
// ALU, iterative shift-add multiply and a registered EX/MEM slot.
module execute_stage_p
  import execute_stage_p_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NFWD  = 4,
  parameter int SELW  = $clog2(NFWD + 1)
) (
  input logic              clk,
  input logic              reset,
  execute_stage_p_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mux1, mux2, opa, opb, ra_sel_v;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [WIDTH-1:0]  alu_q, alu_d, ra_q, ra_d;
  logic [1:0]        ccr_q, ccr_d;

  logic [2*WIDTH-1:0] ma_q, ma_d, acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   mb_q, mb_d, mra_q, mra_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mpass_q, mpass_d;
  logic               mccr_q, mccr_d;
  logic               mwb_q, mwb_d;

  logic busy, slot_free, in_rdy, accept, is_mul, pass;
  logic load_s, load_m, mul_done;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic             rz, rc, wz, wc;

  assign mux1 = bus.src1_imm ? bus.simm : bus.rf_out1;
  assign mux2 = bus.src2_imm ? bus.simm : bus.rf_out2;

  fwd_mux_p #(.WIDTH(WIDTH), .NFWD(NFWD), .SELW(SELW)) u_fwd1 (
    .sel_i  (bus.fwd_sel1),
    .data_i (bus.fwd_data),
    .mux_i  (mux1),
    .y_o    (opa)
  );

  fwd_mux_p #(.WIDTH(WIDTH), .NFWD(NFWD), .SELW(SELW)) u_fwd2 (
    .sel_i  (bus.fwd_sel2),
    .data_i (bus.fwd_data),
    .mux_i  (mux2),
    .y_o    (opb)
  );

  assign ra_sel_v  = bus.ra_sel ? opa : bus.pc_plus1;
  assign busy      = (state_q == MUL);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_rdy    = reset && !busy && slot_free && !bus.flush;
  assign accept    = bus.in_valid && in_rdy;
  assign is_mul    = (bus.op == OP_MUL);
  assign pass      = cond_pass(bus.cond, ccr_q);
  assign load_s    = accept && !is_mul;

  // The final shift-add step is folded into the slot load.
  assign acc_step = acc_q + (mb_q[0] ? ma_q : '0);
  assign prod     = (cnt_q == '0) ? acc_q : acc_step;
  assign mul_done = (cnt_q <= CW'(1));
  assign load_m   = busy && mul_done && slot_free && !bus.flush;

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    res = opb;
    rc  = 1'b0;
    wz  = 1'b0;
    wc  = 1'b0;
    unique case (1'b1)
      bus.op == OP_ADD: begin
        res = sum[WIDTH-1:0];
        rc  = sum[WIDTH];
        wz  = 1'b1;
        wc  = 1'b1;
      end
      bus.op == OP_NAND: begin
        res = ~(opa & opb);
        wz  = 1'b1;
      end
      bus.op == OP_SUB: begin
        res = diff[WIDTH-1:0];
        rc  = diff[WIDTH];
        wz  = 1'b1;
        wc  = 1'b1;
      end
      default: ;
    endcase
    rz = (res == '0);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    ra_d        = ra_q;
    wb_en_d     = wb_en_q;
    ccr_d       = ccr_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mpass_d     = mpass_q;
    mccr_d      = mccr_q;
    mwb_d       = mwb_q;
    mra_d       = mra_q;

    if (load_s || load_m) out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;

    if (load_s) begin
      alu_d   = res;
      ra_d    = ra_sel_v;
      wb_en_d = bus.wb_en_in && pass;
      if (bus.ccr_en && pass) begin
        if (wz) ccr_d[CCR_Z] = rz;
        if (wc) ccr_d[CCR_C] = rc;
      end
    end

    if (accept && is_mul) begin
      state_d = MUL;
      ma_d    = {{WIDTH{1'b0}}, opa};
      mb_d    = opb;
      acc_d   = '0;
      cnt_d   = CW'(WIDTH);
      mpass_d = pass;
      mccr_d  = bus.ccr_en;
      mwb_d   = bus.wb_en_in;
      mra_d   = ra_sel_v;
    end

    if (busy && cnt_q != '0) begin
      acc_d = acc_step;
      ma_d  = ma_q << 1;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end

    if (load_m) begin
      state_d = IDLE;
      alu_d   = prod[WIDTH-1:0];
      ra_d    = mra_q;
      wb_en_d = mwb_q && mpass_q;
      if (mccr_q && mpass_q) begin
        ccr_d[CCR_Z] = (prod[WIDTH-1:0] == '0);
        ccr_d[CCR_C] = (prod[2*WIDTH-1:WIDTH] != '0);
      end
    end

    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      ra_q        <= '0;
      wb_en_q     <= 1'b0;
      ccr_q       <= 2'b00;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mpass_q     <= 1'b0;
      mccr_q      <= 1'b0;
      mwb_q       <= 1'b0;
      mra_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      ra_q        <= ra_d;
      wb_en_q     <= wb_en_d;
      ccr_q       <= ccr_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mpass_q     <= mpass_d;
      mccr_q      <= mccr_d;
      mwb_q       <= mwb_d;
      mra_q       <= mra_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_q;
  assign bus.ra_out    = ra_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.ccr       = ccr_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_execute_stage_p.sv
// Scoreboard bench for execute_stage_p: expected slot contents are
// queued at issue and compared when the slot is consumed.
module tb_execute_stage_p;
  import execute_stage_p_pkg::*;

  localparam int W  = 16;
  localparam int NF = 4;
  localparam logic [W-1:0] PC = 16'h0100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  execute_stage_p_if #(.WIDTH(W), .NFWD(NF)) bus ();

  execute_stage_p #(.WIDTH(W), .NFWD(NF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] ra;
    logic         wb;
    logic [1:0]   ccr;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic [1:0] m_ccr = 2'b00;

  function automatic exp_t model(
    input logic [2:0] op,
    input logic [W-1:0] a, b, ra,
    input logic [1:0] cond,
    input logic ce, wbi
  );
    exp_t e;
    logic p_ok;
    logic [W:0] s;
    logic [2*W-1:0] p;
    case (cond)
      2'd0: p_ok = 1'b1;
      2'd1: p_ok = m_ccr[0];
      2'd2: p_ok = m_ccr[1];
      default: p_ok = 1'b0;
    endcase
    e.ra = ra;
    e.wb = wbi && p_ok;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.alu = s[W-1:0];
        if (ce && p_ok) m_ccr = {e.alu == 0, s[W]};
      end
      3'd1: begin
        e.alu = ~(a & b);
        if (ce && p_ok) m_ccr[1] = (e.alu == 0);
      end
      3'd2: begin
        e.alu = a - b;
        if (ce && p_ok) m_ccr = {a == b, a < b};
      end
      3'd4: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.alu = p[W-1:0];
        if (ce && p_ok) m_ccr = {e.alu == 0, p[2*W-1:W] != 0};
      end
      default: e.alu = b;
    endcase
    e.ccr = m_ccr;
    return e;
  endfunction

  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output alu=%h (no entry queued)", bus.alu_out);
      end else begin
        e = q.pop_front();
        pops++;
        if (bus.alu_out !== e.alu) begin
          errors++;
          $display("FAIL sb_alu got=%h exp=%h", bus.alu_out, e.alu);
        end
        checks++;
        if (bus.ra_out !== e.ra) begin
          errors++;
          $display("FAIL sb_ra got=%h exp=%h", bus.ra_out, e.ra);
        end
        checks++;
        if (bus.wb_en !== e.wb) begin
          errors++;
          $display("FAIL sb_wb got=%b exp=%b", bus.wb_en, e.wb);
        end
        checks++;
        if (bus.ccr !== e.ccr) begin
          errors++;
          $display("FAIL sb_ccr got=%b exp=%b", bus.ccr, e.ccr);
        end
      end
    end
  end

  task automatic set_ops(input logic [W-1:0] r1, r2);
    bus.rf_out1  = r1;
    bus.rf_out2  = r2;
    bus.simm     = '0;
    bus.src1_imm = 1'b0;
    bus.src2_imm = 1'b0;
    bus.fwd_sel1 = '0;
    bus.fwd_sel2 = '0;
    bus.ra_sel   = 1'b0;
    bus.pc_plus1 = PC;
  endtask

  task automatic send(
    input logic [2:0] op,
    input logic [W-1:0] a, b, ra,
    input logic [1:0] cond,
    input logic ce, wbi,
    input bit keep,
    output int waits
  );
    exp_t e;
    bus.op       = op;
    bus.cond     = cond;
    bus.ccr_en   = ce;
    bus.wb_en_in = wbi;
    bus.in_valid = 1'b1;
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b exp=1", bus.in_ready);
    end else if (keep) begin
      e = model(op, a, b, ra, cond, ce, wbi);
      q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush = 1'b0;
    bus.op = OP_ADD;
    bus.cond = COND_ALWAYS;
    bus.ccr_en = 1'b1;
    bus.wb_en_in = 1'b1;
    bus.fwd_data = '0;
    set_ops(16'd1, 16'd2);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.ccr !== 2'b00) begin
      errors++; $display("FAIL rst_ccr got=%b exp=00", bus.ccr);
    end
    checks++;
    if (bus.alu_out !== '0 || bus.ra_out !== '0) begin
      errors++;
      $display("FAIL rst_data got=%h/%h exp=0/0", bus.alu_out, bus.ra_out);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_wb got=%b%b exp=00", bus.busy, bus.wb_en);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_add_carry;
    int w;
    bus.out_ready = 1'b1;
    set_ops(16'hFFFF, 16'h0001);
    send(OP_ADD, 16'hFFFF, 16'h0001, PC, COND_ALWAYS, 1, 1, 1, w);
    #1;
    checks++;
    if (bus.alu_out !== 16'h0000 || bus.ccr !== 2'b11) begin
      errors++;
      $display("FAIL add_carry got=%h/%b exp=0000/11", bus.alu_out, bus.ccr);
    end
    set_ops(16'd3, 16'd4);
    send(OP_ADD, 16'd3, 16'd4, PC, COND_Z, 1, 1, 1, w);
    #1;
    checks++;
    if (bus.alu_out !== 16'd7 || bus.ccr !== 2'b00 || bus.wb_en !== 1'b1) begin
      errors++;
      $display("FAIL add_ifz got=%h/%b/%b exp=0007/00/1",
               bus.alu_out, bus.ccr, bus.wb_en);
    end
  endtask

  task automatic test_forward;
    int w;
    @(negedge clk);
    bus.fwd_data = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5555};
    set_ops(16'h0000, 16'h0000);
    bus.fwd_sel1 = 3'd2;
    bus.src2_imm = 1'b1;
    bus.simm = 16'd5;
    bus.ra_sel = 1'b1;
    send(OP_PASSB, 16'h1234, 16'd5, 16'h1234, COND_ALWAYS, 1, 1, 1, w);
    #1;
    checks++;
    if (bus.ra_out !== 16'h1234 || bus.alu_out !== 16'd5) begin
      errors++;
      $display("FAIL fwd_slot1 got=%h/%h exp=1234/0005", bus.ra_out, bus.alu_out);
    end
    set_ops(16'hAAAA, 16'h0000);
    bus.fwd_sel1 = 3'd7;
    bus.fwd_sel2 = 3'd4;
    bus.ra_sel = 1'b1;
    send(OP_PASSB, 16'hAAAA, 16'hDEAD, 16'hAAAA, COND_ALWAYS, 0, 1, 1, w);
    set_ops(16'h0000, 16'h0000);
    bus.src1_imm = 1'b1;
    bus.simm = 16'h0042;
    bus.fwd_sel2 = 3'd1;
    bus.ra_sel = 1'b1;
    send(OP_ADD, 16'h0042, 16'h5555, 16'h0042, COND_ALWAYS, 0, 1, 1, w);
  endtask

  task automatic test_ops;
    int w;
    @(negedge clk);
    set_ops(16'd5, 16'd7);
    send(OP_SUB, 16'd5, 16'd7, PC, COND_ALWAYS, 1, 1, 1, w);
    set_ops(16'hFFFF, 16'hFFFF);
    send(OP_NAND, 16'hFFFF, 16'hFFFF, PC, COND_C, 1, 1, 1, w);
    set_ops(16'd1, 16'd1);
    send(OP_ADD, 16'd1, 16'd1, PC, COND_NEVER, 1, 1, 1, w);
    set_ops(16'd9, 16'd9);
    send(OP_SUB, 16'd9, 16'd9, PC, COND_ALWAYS, 1, 1, 1, w);
    set_ops(16'd4, 16'd4);
    send(OP_ADD, 16'd4, 16'd4, PC, COND_C, 1, 1, 1, w);
    set_ops(16'd1, 16'd0);
    send(3'd6, 16'd1, 16'd0, PC, COND_ALWAYS, 1, 1, 1, w);
  endtask

  task automatic test_mul;
    int w, cyc;
    bit bad;
    @(negedge clk);
    set_ops(16'd300, 16'd300);
    send(OP_MUL, 16'd300, 16'd300, PC, COND_ALWAYS, 1, 1, 1, w);
    set_ops(16'hFFFF, 16'hFFFF);
    cyc = 0;
    bad = 0;
    while (bus.busy && cyc < 100) begin
      if (bus.in_ready !== 1'b0) bad = 1;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != W) begin
      errors++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", cyc, W);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL mul_in_ready got=1 exp=0 while busy");
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_out !== 16'h5F90 || bus.ccr !== 2'b01) begin
      errors++;
      $display("FAIL mul_result got=%b/%h/%b exp=1/5f90/01",
               bus.out_valid, bus.alu_out, bus.ccr);
    end
    set_ops(16'h0100, 16'h0100);
    send(OP_MUL, 16'h0100, 16'h0100, PC, COND_ALWAYS, 1, 1, 1, w);
    set_ops(16'd7, 16'd9);
    bus.ra_sel = 1'b1;
    send(OP_MUL, 16'd7, 16'd9, 16'd7, COND_C, 1, 1, 1, w);
    set_ops(16'hFFFF, 16'h1111);
    bus.fwd_data = '1;
  endtask

  task automatic test_backpressure;
    int p0;
    @(negedge clk);
    bus.fwd_data = '0;
    while (q.size() != 0 && p0 < 100) begin
      @(negedge clk);
      p0++;
    end
    p0 = pops;
    bus.out_ready = 1'b0;
    set_ops(16'd10, 16'd20);
    begin
      int w;
      send(OP_ADD, 16'd10, 16'd20, PC, COND_ALWAYS, 1, 1, 1, w);
    end
    set_ops(16'd5, 16'd6);
    bus.op = OP_ADD;
    bus.cond = COND_ALWAYS;
    bus.ccr_en = 1'b1;
    bus.wb_en_in = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_out !== 16'd30) begin
        errors++;
        $display("FAIL bp_hold got=%b/%b/%h exp=0/1/001e",
                 bus.in_ready, bus.out_valid, bus.alu_out);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=%b exp=1", bus.in_ready);
    end else begin
      q.push_back(model(OP_ADD, 16'd5, 16'd6, PC, COND_ALWAYS, 1, 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (pops != p0 + 2 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got=%0d/%0d exp=%0d/0", pops - p0, q.size(), 2);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [W-1:0] a, b;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      set_ops(a, b);
      send((i % 2 == 0) ? OP_ADD : OP_SUB, a, b, PC, COND_ALWAYS, 1, 1, 1, w);
      checks++;
      if (w != 0) begin
        errors++; $display("FAIL b2b_stall_%0d got=%0d exp=0", i, w);
      end
    end
  endtask

  task automatic test_flush;
    int w;
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_ops(16'd300, 16'd300);
    send(OP_MUL, 16'd300, 16'd300, PC, COND_ALWAYS, 1, 1, 0, w);
    repeat (7) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ccr !== m_ccr) begin
      errors++;
      $display("FAIL flush_mul got=%b/%b/%b exp=0/0/%b",
               bus.busy, bus.out_valid, bus.ccr, m_ccr);
    end
    set_ops(16'd1, 16'd1);
    send(OP_ADD, 16'd1, 16'd1, PC, COND_ALWAYS, 0, 1, 1, w);
    checks++;
    if (w != 0) begin
      errors++; $display("FAIL flush_next_wait got=%0d exp=0", w);
    end
    #1;
    checks++;
    if (bus.alu_out !== 16'd2) begin
      errors++; $display("FAIL flush_next_alu got=%h exp=0002", bus.alu_out);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_ops(16'd2, 16'd3);
    send(OP_ADD, 16'd2, 16'd3, PC, COND_ALWAYS, 0, 1, 0, w);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_slot got=%b exp=0", bus.out_valid);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_add_carry;
    test_forward;
    test_ops;
    test_mul;
    test_backpressure;
    test_back_to_back;
    test_flush;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL sb_drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
